// File: rtl/dsp_pkg.sv
// Shared types and constants for the shared iterative divider.
package dsp_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/seq_div_core.sv
// Restoring shift-subtract divider datapath: one quotient bit per step.
module seq_div_core
    import dsp_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    logic [N-1:0] quo_q;
    logic [N-1:0] rem_q;
    logic [N-1:0] dsr_q;
    logic [N:0]   partial;
    logic [N-1:0] rem_sub;
    logic         fits;

    // The shifted partial remainder is below 2*divisor, so the N-bit
    // wrap-around subtraction yields the exact difference whenever it fits.
    always_comb begin
        partial = {rem_q, quo_q[N-1]};
        fits    = (partial >= {1'b0, dsr_q});
        rem_sub = partial[N-1:0] - dsr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            dsr_q <= divisor;
            if (divisor == '0) begin
                quo_q <= '1;
                rem_q <= dividend;
            end else begin
                quo_q <= dividend;
                rem_q <= '0;
            end
        end else if (step) begin
            quo_q <= {quo_q[N-2:0], fits};
            rem_q <= fits ? rem_sub : partial[N-1:0];
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_share_ctrl.sv
// Two-requester round-robin front end sequencing one shared iterative divider.
module div_share_ctrl
    import dsp_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_dividend,
    input  logic [N-1:0] req0_divisor,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_dividend,
    input  logic [N-1:0] req1_divisor,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          last_id;
    logic          grant_any;
    logic          grant_id;
    logic          load;
    logic          step;
    logic [N-1:0]  sel_dividend;
    logic [N-1:0]  sel_divisor;

    // Contention goes to the requester not served last; otherwise to whoever asks.
    assign grant_any    = req0_valid | req1_valid;
    assign grant_id     = (req0_valid & req1_valid) ? ~last_id : req1_valid;
    assign sel_dividend = (grant_id == ID_REQ1) ? req1_dividend : req0_dividend;
    assign sel_divisor  = (grant_id == ID_REQ1) ? req1_divisor  : req0_divisor;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = (grant_id == ID_REQ0);
                    req1_ready = (grant_id == ID_REQ1);
                    load       = 1'b1;
                    state_nxt  = (sel_divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_id     <= ID_REQ1;
            res_id      <= ID_REQ0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt         <= (sel_divisor == '0) ? '0 : CW'(N);
                last_id     <= grant_id;
                res_id      <= grant_id;
                div_by_zero <= (sel_divisor == '0);
            end else if (step) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    seq_div_core #(
        .N(N)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .dividend (sel_dividend),
        .divisor  (sel_divisor),
        .quotient (quotient),
        .remainder(remainder)
    );

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench: transaction-level reference model plus directed and random traffic.
module tb_div_share_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [N-1:0] req0_dividend = '0;
    logic [N-1:0] req0_divisor = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [N-1:0] req1_dividend = '0;
    logic [N-1:0] req1_divisor = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         res_id;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    always #5 clk = ~clk;

    div_share_ctrl #(
        .N(N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_dividend(req0_dividend),
        .req0_divisor (req0_divisor),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_dividend(req1_dividend),
        .req1_divisor (req1_divisor),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .busy         (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one outstanding job, result due at a fixed cycle.
    int           cyc = 0;
    bit           m_known = 0;
    bit           m_fresh = 0;
    bit           m_job = 0;
    bit           m_last = 1;
    int           m_done_at = 0;
    logic [N-1:0] m_q, m_r;
    bit           m_dbz, m_id;
    int           m_accepts = 0;
    int           m_acc_id[2] = '{0, 0};

    always @(negedge clk) begin : model
        bit           exp_rv, g_any, g_id;
        logic [N-1:0] a, b;
        cyc++;
        exp_rv = 1'b0;
        g_any  = 1'b0;
        g_id   = 1'b0;
        if (m_known) begin
            exp_rv = m_job && (cyc >= m_done_at);
            g_any  = !m_job && (req0_valid || req1_valid);
            g_id   = (req0_valid && req1_valid) ? !m_last : req1_valid;
            check("busy", 32'(busy), 32'(m_job));
            check("res_valid", 32'(res_valid), 32'(exp_rv));
            check("req0_ready", 32'(req0_ready), 32'(g_any && !g_id));
            check("req1_ready", 32'(req1_ready), 32'(g_any && g_id));
            if (exp_rv) begin
                check("res_id", 32'(res_id), 32'(m_id));
                check("quotient", 32'(quotient), 32'(m_q));
                check("remainder", 32'(remainder), 32'(m_r));
                check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
            end else if (m_fresh && !m_job) begin
                check("rst_quotient", 32'(quotient), 32'h0);
                check("rst_remainder", 32'(remainder), 32'h0);
                check("rst_res_id", 32'(res_id), 32'h0);
                check("rst_div_by_zero", 32'(div_by_zero), 32'h0);
            end
        end
        if (reset) begin
            m_known = 1;
            m_job   = 0;
            m_last  = 1;
            m_fresh = 1;
        end else if (m_known) begin
            if (g_any) begin
                a = g_id ? req1_dividend : req0_dividend;
                b = g_id ? req1_divisor : req0_divisor;
                if (b == '0) begin
                    m_q = '1;
                    m_r = a;
                    m_dbz = 1;
                    m_done_at = cyc + 1;
                end else begin
                    m_q = a / b;
                    m_r = a % b;
                    m_dbz = 0;
                    m_done_at = cyc + N + 1;
                end
                m_id = g_id;
                m_last = g_id;
                m_job = 1;
                m_fresh = 0;
                m_accepts++;
                m_acc_id[g_id]++;
            end else if (exp_rv && res_ready) begin
                m_job = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input int limit, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < limit);
        check("result_arrived", 32'(res_valid), 32'h1);
    endtask

    function automatic logic [N-1:0] rand_divisor();
        case ($urandom_range(0, 7))
            0:       return '0;
            1, 2:    return N'($urandom_range(1, 15));
            3:       return '1;
            default: return N'($urandom);
        endcase
    endfunction

    function automatic logic [N-1:0] rand_dividend();
        case ($urandom_range(0, 5))
            0:       return N'($urandom_range(0, 20));
            1:       return '1;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        int base;
        int iter;
        bit seen;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("lit_reset_busy", 32'(busy), 32'h0);
        check("lit_reset_quotient", 32'(quotient), 32'h0);

        // 100/7 on req0, result held 5 cycles while req1 waits with a zero divisor.
        tick();
        req0_valid = 1'b1; req0_dividend = 16'd100; req0_divisor = 16'd7;
        @(negedge clk);
        check("lit_d1_ready0", 32'(req0_ready), 32'h1);
        tick();
        req0_valid = 1'b0; req0_dividend = 16'hBEEF; req0_divisor = 16'd3;
        req1_valid = 1'b1; req1_dividend = 16'd1234; req1_divisor = 16'd0;
        wait_result(40, k);
        check("lit_d1_latency", 32'(k), 32'd17);
        check("lit_d1_quotient", 32'(quotient), 32'd14);
        check("lit_d1_remainder", 32'(remainder), 32'd2);
        check("lit_d1_res_id", 32'(res_id), 32'h0);
        check("lit_d1_dbz", 32'(div_by_zero), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lit_hold_quotient", 32'(quotient), 32'd14);
            check("lit_hold_ready1", 32'(req1_ready), 32'h0);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        check("lit_hs_no_accept", 32'(req1_ready), 32'h0);
        tick();
        @(negedge clk);
        check("lit_post_hs_accept", 32'(req1_ready), 32'h1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        check("lit_dz_res_valid", 32'(res_valid), 32'h1);
        check("lit_dz_quotient", 32'(quotient), 32'hFFFF);
        check("lit_dz_remainder", 32'(remainder), 32'd1234);
        check("lit_dz_flag", 32'(div_by_zero), 32'h1);
        check("lit_dz_res_id", 32'(res_id), 32'h1);

        // Contention straight after reset, then a second contention.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_dividend = 16'd1000;  req0_divisor = 16'd10;
        req1_valid = 1'b1; req1_dividend = 16'd65535; req1_divisor = 16'd255;
        @(negedge clk);
        check("lit_c1_ready0", 32'(req0_ready), 32'h1);
        check("lit_c1_ready1", 32'(req1_ready), 32'h0);
        tick();
        wait_result(40, k);
        check("lit_c1_quotient", 32'(quotient), 32'd100);
        check("lit_c1_remainder", 32'(remainder), 32'd0);
        tick();
        @(negedge clk);
        check("lit_c2_ready1", 32'(req1_ready), 32'h1);
        check("lit_c2_ready0", 32'(req0_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        wait_result(40, k);
        check("lit_c2_quotient", 32'(quotient), 32'd257);
        check("lit_c2_remainder", 32'(remainder), 32'd0);
        check("lit_c2_res_id", 32'(res_id), 32'h1);
        tick();
        req1_valid = 1'b0;

        // Reset in RUN cycle 8 discards the job.
        req0_valid = 1'b1; req0_dividend = 16'd60000; req0_divisor = 16'd7;
        @(negedge clk);
        check("lit_r_accept", 32'(req0_ready), 32'h1);
        tick();
        req0_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("lit_r_busy", 32'(busy), 32'h0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= res_valid;
        end
        check("lit_r_no_result", 32'(seen), 32'h0);
        tick();
        req0_valid = 1'b1; req0_dividend = 16'd9; req0_divisor = 16'd3;
        @(negedge clk);
        tick();
        req0_valid = 1'b0;
        wait_result(40, k);
        check("lit_r_quotient", 32'(quotient), 32'd3);
        check("lit_r_remainder", 32'(remainder), 32'd0);
        tick();

        // Random sweep against the model.
        base = m_accepts;
        iter = 0;
        while ((m_accepts - base) < 1100 && iter < 60000) begin
            req0_valid    = ($urandom_range(0, 3) != 0);
            req1_valid    = ($urandom_range(0, 3) != 0);
            req0_dividend = rand_dividend();
            req0_divisor  = rand_divisor();
            req1_dividend = rand_dividend();
            req1_divisor  = rand_divisor();
            res_ready     = ($urandom_range(0, 2) != 0);
            tick();
            iter++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        repeat (40) tick();
        check("rand_accepts", 32'((m_accepts - base) >= 1000), 32'h1);
        check("rand_req0_served", 32'(m_acc_id[0] > 0), 32'h1);
        check("rand_req1_served", 32'(m_acc_id[1] > 0), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
